// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: FSM state codes and the IncrReg ctrl codes.
package pc_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StClrPc = 3'd1;
    localparam state_t StFetch = 3'd2;
    localparam state_t StExec  = 3'd3;
    localparam state_t StHalt  = 3'd4;

    typedef logic [1:0] pc_ctrl_t;

    localparam pc_ctrl_t PC_HOLD  = 2'b00;
    localparam pc_ctrl_t PC_LOAD  = 2'b01;
    localparam pc_ctrl_t PC_INCR  = 2'b10;
    localparam pc_ctrl_t PC_CLEAR = 2'b11;

    function automatic logic is_busy(state_t s);
        return !((s == StIdle) || (s == StHalt));
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/execute handshake bundle between the PC sequencer and its surroundings.
// Interrupt signals exist only when PC_SEQ_IRQ_EN is defined.
interface pc_sequencer_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic         halt_req;
    logic         mem_req;
    logic         mem_ack;
    logic         ir_ld;
    logic         exec_start;
    logic         exec_done;
    logic         br_taken;
    logic [N-1:0] br_target;
    logic [N-1:0] pc_cur;
    logic [1:0]   pc_ctrl;
    logic [N-1:0] pc_in;
    logic         busy;
    logic         halted;
`ifdef PC_SEQ_IRQ_EN
    logic         irq;
    logic         irq_ret;
    logic         irq_ack;
    logic [N-1:0] epc;

    modport master (
        input  start, halt_req, mem_ack, exec_done, br_taken, br_target, pc_cur, irq, irq_ret,
        output mem_req, ir_ld, exec_start, pc_ctrl, pc_in, busy, halted, irq_ack, epc
    );
    modport slave (
        output start, halt_req, mem_ack, exec_done, br_taken, br_target, pc_cur, irq, irq_ret,
        input  mem_req, ir_ld, exec_start, pc_ctrl, pc_in, busy, halted, irq_ack, epc
    );
`else
    modport master (
        input  start, halt_req, mem_ack, exec_done, br_taken, br_target, pc_cur,
        output mem_req, ir_ld, exec_start, pc_ctrl, pc_in, busy, halted
    );
    modport slave (
        output start, halt_req, mem_ack, exec_done, br_taken, br_target, pc_cur,
        input  mem_req, ir_ld, exec_start, pc_ctrl, pc_in, busy, halted
    );
`endif
endinterface

// File: rtl/pc_seq_irq_unit.sv
// Interrupt bookkeeping for the PC sequencer: saved return PC, nesting flag and
// accept/return decode. Instantiated only when PC_SEQ_IRQ_EN is defined.
module pc_seq_irq_unit #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         done_i,
    input  logic         halt_req_i,
    input  logic         irq_i,
    input  logic         irq_ret_i,
    input  logic         br_taken_i,
    input  logic [N-1:0] br_target_i,
    input  logic [N-1:0] pc_cur_i,
    output logic         accept_o,
    output logic         return_o,
    output logic [N-1:0] epc_o
);

    logic [N-1:0] epc_q, epc_d;
    logic         in_irq_q, in_irq_d;

    // halt_req outranks both; a return outranks a new interrupt
    assign return_o = done_i && !halt_req_i && irq_ret_i;
    assign accept_o = done_i && !halt_req_i && !irq_ret_i && irq_i && !in_irq_q;

    always_comb begin
        epc_d    = epc_q;
        in_irq_d = in_irq_q;
        if (accept_o) begin
            epc_d    = br_taken_i ? br_target_i : pc_cur_i;
            in_irq_d = 1'b1;
        end else if (return_o) begin
            in_irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            epc_q    <= '0;
            in_irq_q <= 1'b0;
        end else begin
            epc_q    <= epc_d;
            in_irq_q <= in_irq_d;
        end
    end

    assign epc_o = epc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving an external IncrReg program counter.
// Optional interrupt support is compiled in with PC_SEQ_IRQ_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned N = 8
`ifdef PC_SEQ_IRQ_EN
    ,
    parameter logic [N-1:0] IRQ_VEC = 8'hF0
`endif
) (
    input logic              clk,
    input logic              clr,
    pc_sequencer_if.master   bus
);

    state_t       state_q, state_d;
    logic         exec_first_q, exec_first_d;
    pc_ctrl_t     pc_ctrl;
    logic [N-1:0] pc_in;
    logic         ir_ld;
    logic         done_ev;
    logic         irq_accept;
    logic         irq_return;
    logic [N-1:0] epc;

    assign done_ev = (state_q == StExec) && bus.exec_done;

`ifdef PC_SEQ_IRQ_EN
    localparam logic [N-1:0] IrqVec = IRQ_VEC;

    pc_seq_irq_unit #(
        .N (N)
    ) u_irq (
        .clk_i       (clk),
        .clr_i       (clr),
        .done_i      (done_ev),
        .halt_req_i  (bus.halt_req),
        .irq_i       (bus.irq),
        .irq_ret_i   (bus.irq_ret),
        .br_taken_i  (bus.br_taken),
        .br_target_i (bus.br_target),
        .pc_cur_i    (bus.pc_cur),
        .accept_o    (irq_accept),
        .return_o    (irq_return),
        .epc_o       (epc)
    );

    assign bus.irq_ack = irq_accept;
    assign bus.epc     = epc;
`else
    localparam logic [N-1:0] IrqVec = '0;

    logic unused_pc_cur;
    logic unused_done_ev;

    assign irq_accept     = 1'b0;
    assign irq_return     = 1'b0;
    assign epc            = '0;
    assign unused_pc_cur  = ^bus.pc_cur;
    assign unused_done_ev = done_ev;
`endif

    always_comb begin
        state_d      = state_q;
        exec_first_d = 1'b0;
        pc_ctrl      = PC_HOLD;
        pc_in        = '0;
        ir_ld        = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StClrPc;
            end
            StClrPc: begin
                pc_ctrl = PC_CLEAR;
                state_d = StFetch;
            end
            StFetch: begin
                if (bus.mem_ack) begin
                    ir_ld        = 1'b1;
                    pc_ctrl      = PC_INCR;
                    exec_first_d = 1'b1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (bus.exec_done) begin
                    // The PC load applies whether we go on to FETCH or stop in HALT
                    if (irq_return) begin
                        pc_ctrl = PC_LOAD;
                        pc_in   = epc;
                    end else if (irq_accept) begin
                        pc_ctrl = PC_LOAD;
                        pc_in   = IrqVec;
                    end else if (bus.br_taken) begin
                        pc_ctrl = PC_LOAD;
                        pc_in   = bus.br_target;
                    end
                    state_d = bus.halt_req ? StHalt : StFetch;
                end
            end
            StHalt: begin
                if (bus.start && !bus.halt_req) state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= StIdle;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= exec_first_d;
        end
    end

    assign bus.mem_req    = (state_q == StFetch);
    assign bus.busy       = is_busy(state_q);
    assign bus.halted     = (state_q == StHalt);
    assign bus.exec_start = exec_first_q;
    assign bus.ir_ld      = ir_ld;
    assign bus.pc_ctrl    = pc_ctrl;
    assign bus.pc_in      = pc_in;

endmodule
